// File: rtl/m2_sram_arbiter_if.sv
// Bus bundle between the SRAM arbiter, its requesters and the external SRAM port.
// The master modport is the requester/SRAM side and the slave modport is the arbiter.
interface m2_sram_arbiter_if #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = 18,
  parameter int unsigned DATA_W  = 16
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we_n;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rd_valid;
  logic [DATA_W-1:0]         rd_data;
  logic                      busy;
  logic [ADDR_W-1:0]         SRAM_address;
  logic                      SRAM_we_n;
  logic [DATA_W-1:0]         SRAM_write_data;
  logic [DATA_W-1:0]         SRAM_read_data;

  modport master (
    output req, req_we_n, req_addr, req_wdata, SRAM_read_data,
    input  gnt, rd_valid, rd_data, busy, SRAM_address, SRAM_we_n, SRAM_write_data
  );

  modport slave (
    input  req, req_we_n, req_addr, req_wdata, SRAM_read_data,
    output gnt, rd_valid, rd_data, busy, SRAM_address, SRAM_we_n, SRAM_write_data
  );
endinterface

// File: rtl/m2_sram_arbiter.sv
// Round-robin arbiter sharing one external SRAM port among NUM_REQ requesters, with bounded
// burst ownership, a single idle turnaround cycle per owner change and id-tagged read returns.
module m2_sram_arbiter #(
  parameter int unsigned       NUM_REQ    = 3,
  parameter int unsigned       ADDR_W     = 18,
  parameter int unsigned       DATA_W     = 16,
  parameter int unsigned       RD_LATENCY = 2,
  parameter int unsigned       MAX_BURST  = 64,
  parameter logic [ADDR_W-1:0] PARK_ADDR  = '0
) (
  input logic               clock,
  input logic               reset,
  m2_sram_arbiter_if.slave  bus
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  logic [0:0]                           state_q, state_d;
  logic [ID_W-1:0]                      owner_q, owner_d;
  logic [ID_W-1:0]                      rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]                     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]                   gnt_q, gnt_d;
  logic [RD_LATENCY-1:0][NUM_REQ-1:0]   rd_pipe_q, rd_pipe_d;
  logic                                 busy_q, busy_d;

  logic [NUM_REQ-1:0] owner_oh_c;
  logic               own_req_c;
  logic               own_we_n_c;
  logic [ADDR_W-1:0]  own_addr_c;
  logic [DATA_W-1:0]  own_wdata_c;
  logic               beat_c;
  logic               other_pend_c;
  logic               pick_vld_c;
  logic [ID_W-1:0]    pick_id_c;
  logic [ID_W-1:0]    cand_c;

  // Owner's request mux; a beat is blocked combinationally while reset is held
  always_comb begin
    owner_oh_c   = NUM_REQ'(1) << owner_q;
    own_req_c    = bus.req[owner_q];
    own_we_n_c   = bus.req_we_n[owner_q];
    own_addr_c   = bus.req_addr[int'(owner_q)*ADDR_W +: ADDR_W];
    own_wdata_c  = bus.req_wdata[int'(owner_q)*DATA_W +: DATA_W];
    beat_c       = (state_q == ST_OWN) & own_req_c & gnt_q[owner_q] & ~reset;
    other_pend_c = |(bus.req & ~owner_oh_c);
  end

  // Round-robin pick: scan downwards so the requester nearest after rr_ptr wins last
  always_comb begin
    pick_vld_c = 1'b0;
    pick_id_c  = '0;
    cand_c     = '0;
    for (int k = int'(NUM_REQ); k >= 1; k--) begin
      cand_c = ID_W'((int'(rr_ptr_q) + k) % int'(NUM_REQ));
      if (bus.req[cand_c]) begin
        pick_vld_c = 1'b1;
        pick_id_c  = cand_c;
      end
    end
  end

  // Next-state and tag pipeline
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    rd_pipe_d = '0;
    busy_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_vld_c) begin
          state_d  = ST_OWN;
          owner_d  = pick_id_c;
          rr_ptr_d = pick_id_c;
          cnt_d    = '0;
          gnt_d    = NUM_REQ'(1) << pick_id_c;
        end
      end
      ST_OWN: begin
        if (!own_req_c) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(MAX_BURST - 1)) begin
          // Burst limit: release only if someone else is waiting, otherwise wrap silently
          cnt_d = '0;
          if (other_pend_c) begin
            state_d = ST_IDLE;
            gnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase

    rd_pipe_d[0] = (beat_c & own_we_n_c) ? owner_oh_c : '0;
    for (int i = 1; i < int'(RD_LATENCY); i++) begin
      rd_pipe_d[i] = rd_pipe_q[i-1];
    end
    busy_d = (|gnt_d) | (|rd_pipe_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= ID_W'(NUM_REQ - 1);
      cnt_q     <= '0;
      gnt_q     <= '0;
      rd_pipe_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      rd_pipe_q <= rd_pipe_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.gnt             = gnt_q;
  assign bus.rd_valid        = rd_pipe_q[RD_LATENCY-1];
  assign bus.rd_data         = bus.SRAM_read_data;
  assign bus.busy            = busy_q;
  assign bus.SRAM_address    = beat_c ? own_addr_c : PARK_ADDR;
  assign bus.SRAM_we_n       = ~(beat_c & ~own_we_n_c);
  assign bus.SRAM_write_data = (beat_c & ~own_we_n_c) ? own_wdata_c : '0;

endmodule

// File: tb/tb_m2_sram_arbiter.sv
// Directed bench for m2_sram_arbiter: a per-cycle vector table plus hand-written
// sequences for burst limit, long single-owner bursts and mid-operation reset.
module tb_m2_sram_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  m2_sram_arbiter_if #(.NUM_REQ(3), .ADDR_W(18), .DATA_W(16)) bus_a ();
  m2_sram_arbiter_if #(.NUM_REQ(3), .ADDR_W(18), .DATA_W(16)) bus_b ();

  m2_sram_arbiter #(.MAX_BURST(64)) u_dut_a (.clock(clock), .reset(reset), .bus(bus_a));
  m2_sram_arbiter #(.MAX_BURST(4))  u_dut_b (.clock(clock), .reset(reset), .bus(bus_b));

  // SRAM model: read word is a fixed function of the address, two cycles after it
  function automatic logic [15:0] sram_word(input logic [17:0] a);
    return a[15:0] ^ 16'h3C5A;
  endfunction

  logic [17:0] a_d1, a_d2;
  always @(posedge clock) begin
    a_d1 <= bus_a.SRAM_address;
    a_d2 <= a_d1;
  end
  assign bus_a.SRAM_read_data = sram_word(a_d2);
  assign bus_b.SRAM_read_data = 16'h0000;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  we_n;
    logic [17:0] a0;
    logic [17:0] a1;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [2:0]  g;
    logic [2:0]  rv;
    logic        busy;
    logic [17:0] addr;
    logic        we;
    logic [15:0] wd;
    logic [17:0] rda;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic [2:0] req, input logic [2:0] we_n,
                              input logic [17:0] a0, input logic [17:0] a1,
                              input logic [15:0] w0, input logic [15:0] w1,
                              input logic [2:0] g, input logic [2:0] rv, input logic busy,
                              input logic [17:0] addr, input logic we, input logic [15:0] wd,
                              input logic [17:0] rda);
    vec_t v;
    v.rst = rst; v.req = req; v.we_n = we_n; v.a0 = a0; v.a1 = a1; v.w0 = w0; v.w1 = w1;
    v.g = g; v.rv = rv; v.busy = busy; v.addr = addr; v.we = we; v.wd = wd; v.rda = rda;
    return v;
  endfunction

  function automatic logic [2:0] t3_gnt(input int c);
    if (c == 0)            return 3'b000;
    else if (c <= 4)       return 3'b001;
    else if (c == 5)       return 3'b000;
    else if (c <= 8)       return 3'b010;
    else if (c == 9)       return 3'b000;
    else                   return 3'b001;
  endfunction

  vec_t tv [0:17];

  initial begin
    int gaps;
    int addr_errs;

    // T1: R0 alone, 4 reads; then T2/T4: R0 (read, read, write) vs R1 write after reset
    //            rst  req     we_n    a0         a1     w0        w1        g       rv      bsy addr       we  wd        rda
    tv[0]  = mk(1'b0, 3'b001, 3'b111, 18'd76800, 18'd0, 16'h0000, 16'h0000, 3'b000, 3'b000, 1'b0, 18'd0,     1'b1, 16'h0000, 18'd0);
    tv[1]  = mk(1'b0, 3'b001, 3'b111, 18'd76800, 18'd0, 16'h0000, 16'h0000, 3'b001, 3'b000, 1'b1, 18'd76800, 1'b1, 16'h0000, 18'd0);
    tv[2]  = mk(1'b0, 3'b001, 3'b111, 18'd76801, 18'd0, 16'h0000, 16'h0000, 3'b001, 3'b000, 1'b1, 18'd76801, 1'b1, 16'h0000, 18'd0);
    tv[3]  = mk(1'b0, 3'b001, 3'b111, 18'd76802, 18'd0, 16'h0000, 16'h0000, 3'b001, 3'b001, 1'b1, 18'd76802, 1'b1, 16'h0000, 18'd76800);
    tv[4]  = mk(1'b0, 3'b001, 3'b111, 18'd76803, 18'd0, 16'h0000, 16'h0000, 3'b001, 3'b001, 1'b1, 18'd76803, 1'b1, 16'h0000, 18'd76801);
    tv[5]  = mk(1'b0, 3'b000, 3'b111, 18'd0,     18'd0, 16'h0000, 16'h0000, 3'b001, 3'b001, 1'b1, 18'd0,     1'b1, 16'h0000, 18'd76802);
    tv[6]  = mk(1'b0, 3'b000, 3'b111, 18'd0,     18'd0, 16'h0000, 16'h0000, 3'b000, 3'b001, 1'b1, 18'd0,     1'b1, 16'h0000, 18'd76803);
    tv[7]  = mk(1'b0, 3'b000, 3'b111, 18'd0,     18'd0, 16'h0000, 16'h0000, 3'b000, 3'b000, 1'b0, 18'd0,     1'b1, 16'h0000, 18'd0);
    tv[8]  = mk(1'b1, 3'b000, 3'b111, 18'd0,     18'd0, 16'h0000, 16'h0000, 3'b000, 3'b000, 1'b0, 18'd0,     1'b1, 16'h0000, 18'd0);
    tv[9]  = mk(1'b0, 3'b011, 3'b101, 18'd100,   18'd0, 16'h0000, 16'hA5A5, 3'b000, 3'b000, 1'b0, 18'd0,     1'b1, 16'h0000, 18'd0);
    tv[10] = mk(1'b0, 3'b011, 3'b101, 18'd100,   18'd0, 16'h0000, 16'hA5A5, 3'b001, 3'b000, 1'b1, 18'd100,   1'b1, 16'h0000, 18'd0);
    tv[11] = mk(1'b0, 3'b011, 3'b101, 18'd101,   18'd0, 16'h0000, 16'hA5A5, 3'b001, 3'b000, 1'b1, 18'd101,   1'b1, 16'h0000, 18'd0);
    tv[12] = mk(1'b0, 3'b011, 3'b100, 18'd102,   18'd0, 16'h1111, 16'hA5A5, 3'b001, 3'b001, 1'b1, 18'd102,   1'b0, 16'h1111, 18'd100);
    tv[13] = mk(1'b0, 3'b010, 3'b101, 18'd0,     18'd0, 16'h0000, 16'hA5A5, 3'b001, 3'b001, 1'b1, 18'd0,     1'b1, 16'h0000, 18'd101);
    tv[14] = mk(1'b0, 3'b010, 3'b101, 18'd0,     18'd0, 16'h0000, 16'hA5A5, 3'b000, 3'b000, 1'b0, 18'd0,     1'b1, 16'h0000, 18'd0);
    tv[15] = mk(1'b0, 3'b010, 3'b101, 18'd0,     18'd0, 16'h0000, 16'hA5A5, 3'b010, 3'b000, 1'b1, 18'd0,     1'b0, 16'hA5A5, 18'd0);
    tv[16] = mk(1'b0, 3'b000, 3'b111, 18'd0,     18'd0, 16'h0000, 16'h0000, 3'b010, 3'b000, 1'b1, 18'd0,     1'b1, 16'h0000, 18'd0);
    tv[17] = mk(1'b0, 3'b000, 3'b111, 18'd0,     18'd0, 16'h0000, 16'h0000, 3'b000, 3'b000, 1'b0, 18'd0,     1'b1, 16'h0000, 18'd0);

    bus_a.req = 3'b000; bus_a.req_we_n = 3'b111; bus_a.req_addr = '0; bus_a.req_wdata = '0;
    bus_b.req = 3'b000; bus_b.req_we_n = 3'b111; bus_b.req_addr = '0; bus_b.req_wdata = '0;
    reset = 1'b1;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 18; i++) begin
      @(negedge clock);
      reset           = tv[i].rst;
      bus_a.req       = tv[i].req;
      bus_a.req_we_n  = tv[i].we_n;
      bus_a.req_addr  = {18'd0, tv[i].a1, tv[i].a0};
      bus_a.req_wdata = {16'd0, tv[i].w1, tv[i].w0};
      #1;
      chk($sformatf("row%0d gnt", i),       32'(bus_a.gnt),          32'(tv[i].g));
      chk($sformatf("row%0d rd_valid", i),  32'(bus_a.rd_valid),     32'(tv[i].rv));
      chk($sformatf("row%0d busy", i),      32'(bus_a.busy),         32'(tv[i].busy));
      chk($sformatf("row%0d address", i),   32'(bus_a.SRAM_address), 32'(tv[i].addr));
      chk($sformatf("row%0d we_n", i),      32'(bus_a.SRAM_we_n),    32'(tv[i].we));
      if (tv[i].we == 1'b0)
        chk($sformatf("row%0d wdata", i),   32'(bus_a.SRAM_write_data), 32'(tv[i].wd));
      if (tv[i].rv != 3'b000)
        chk($sformatf("row%0d rd_data", i), 32'(bus_a.rd_data),      32'(sram_word(tv[i].rda)));
    end

    // Reset both instances before the hand-written sequences
    @(negedge clock);
    reset = 1'b1;
    bus_a.req = 3'b000; bus_a.req_we_n = 3'b111; bus_a.req_addr = '0; bus_a.req_wdata = '0;
    @(negedge clock);
    reset = 1'b0;

    // T3: burst limit of 4 with R1 pending, then R0 alone keeps the grant across wraps
    for (int c = 0; c < 22; c++) begin
      @(negedge clock);
      bus_b.req = (c < 8) ? 3'b011 : 3'b001;
      #1;
      chk($sformatf("T3 c%0d gnt", c), 32'(bus_b.gnt), 32'(t3_gnt(c)));
    end
    @(negedge clock);
    bus_b.req = 3'b000;

    // T5: R2 alone for 200 beats with MAX_BURST=64, no gap cycles
    @(negedge clock);
    bus_a.req = 3'b100; bus_a.req_we_n = 3'b111; bus_a.req_addr = '0;
    #1;
    chk("T5 first cycle gnt", 32'(bus_a.gnt), 32'(3'b000));
    gaps = 0;
    addr_errs = 0;
    for (int b = 0; b < 200; b++) begin
      @(negedge clock);
      bus_a.req_addr = {18'(b + 1000), 18'd0, 18'd0};
      #1;
      if (bus_a.gnt !== 3'b100) gaps++;
      if (bus_a.SRAM_address !== 18'(b + 1000)) addr_errs++;
    end
    chk("T5 gap cycles", 32'(gaps), 32'd0);
    chk("T5 address errors", 32'(addr_errs), 32'd0);
    @(negedge clock);
    bus_a.req = 3'b000;
    #1;
    chk("T5 release gnt", 32'(bus_a.gnt), 32'(3'b100));
    repeat (4) @(negedge clock);
    #1;
    chk("T5 drained busy", 32'(bus_a.busy), 32'd0);

    // T6: reset with two reads in flight and a write attempted in the reset cycle
    @(negedge clock);
    bus_a.req = 3'b001; bus_a.req_we_n = 3'b111; bus_a.req_addr = {18'd0, 18'd0, 18'd500};
    @(negedge clock);
    bus_a.req_addr = {18'd0, 18'd0, 18'd501};
    @(negedge clock);
    bus_a.req_addr = {18'd0, 18'd0, 18'd502};
    #1;
    chk("T6 pre-reset gnt", 32'(bus_a.gnt), 32'(3'b001));
    @(negedge clock);
    reset = 1'b1;
    bus_a.req_we_n = 3'b110;
    bus_a.req_wdata = {16'd0, 16'd0, 16'hBEEF};
    #1;
    chk("T6 reset-cycle we_n", 32'(bus_a.SRAM_we_n), 32'd1);
    chk("T6 reset-cycle address", 32'(bus_a.SRAM_address), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    bus_a.req = 3'b000; bus_a.req_we_n = 3'b111;
    #1;
    chk("T6 gnt", 32'(bus_a.gnt), 32'd0);
    chk("T6 rd_valid", 32'(bus_a.rd_valid), 32'd0);
    chk("T6 busy", 32'(bus_a.busy), 32'd0);
    chk("T6 we_n", 32'(bus_a.SRAM_we_n), 32'd1);
    @(negedge clock);
    #1;
    chk("T6 rd_valid later", 32'(bus_a.rd_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
